// File: rtl/pmod_i2c_target_if.sv
// pmod_i2c_target_if -- bus bundle between the I2C responder and its surroundings.
//   scl_i / sda_i : pin levels seen by the responder (asynchronous)
//   sda_oe        : responder pulls SDA low when 1
//   wr_en/wr_addr/wr_data : one-cycle register-file write
//   rd_addr / rd_data     : register-file read address (pointer) and contents
//   busy          : responder is selected by the current transfer
// The slave modport is the responder's view; master is the pad/register-file side.
interface pmod_i2c_target_if #(
  parameter int AW = 4
);
  logic          scl_i;
  logic          sda_i;
  logic          sda_oe;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          busy;

  modport slave (
    input  scl_i, sda_i, rd_data,
    output sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );

  modport master (
    output scl_i, sda_i, rd_data,
    input  sda_oe, wr_en, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/pmod_i2c_target.sv
// pmod_i2c_target -- I2C responder with an 8-bit register-pointer protocol.
// A write transfer sets the pointer from its first data byte, then every further
// byte is written to the register file at the (auto-incrementing) pointer.
// A read transfer returns register contents starting at the pointer.
// The clock is never stretched.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : pmod_i2c_target_if.slave (SCL/SDA pins, SDA pull-down, register-file port, busy)
module pmod_i2c_target #(
  parameter logic [6:0] ADDR = 7'h20,
  parameter int         AW   = 4
) (
  input logic              clk,
  input logic              rst,
  pmod_i2c_target_if.slave bus
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDR, ST_ADDR_ACK, ST_PTR, ST_PTR_ACK,
    ST_WDATA, ST_WDATA_ACK, ST_RDATA, ST_RDATA_ACK, ST_WAIT
  } state_t;

  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [1:0]    scl_sync_reg, sda_sync_reg;
  logic          scl_prev_reg, sda_prev_reg;
  state_t        state_reg;
  logic [3:0]    bit_cnt_reg;
  logic [7:0]    shift_reg;
  logic          rw_reg;
  logic [AW-1:0] ptr_reg;
  logic          sda_oe_reg, wr_en_reg, busy_reg;
  logic [AW-1:0] wr_addr_reg;
  logic [7:0]    wr_data_reg;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, byte_done;

  assign scl_s    = scl_sync_reg[1];
  assign sda_s    = sda_sync_reg[1];
  assign scl_rise = scl_s & ~scl_prev_reg;
  assign scl_fall = ~scl_s & scl_prev_reg;
  // SCL must be high and steady in both samples; an SDA edge coinciding with
  // an SCL edge is ordinary data, not a bus condition.
  assign start_det = scl_s & scl_prev_reg & sda_prev_reg & ~sda_s;
  assign stop_det  = scl_s & scl_prev_reg & ~sda_prev_reg & sda_s;
  assign byte_done = (bit_cnt_reg == 4'd8);

  always_ff @(posedge clk) begin
    if (rst) begin
      scl_sync_reg <= 2'b11;
      sda_sync_reg <= 2'b11;
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      state_reg    <= ST_IDLE;
      bit_cnt_reg  <= 4'd0;
      shift_reg    <= 8'd0;
      rw_reg       <= 1'b0;
      ptr_reg      <= '0;
      sda_oe_reg   <= 1'b0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= 8'd0;
      busy_reg     <= 1'b0;
    end else begin
      scl_sync_reg <= {scl_sync_reg[0], bus.scl_i};
      sda_sync_reg <= {sda_sync_reg[0], bus.sda_i};
      scl_prev_reg <= scl_s;
      sda_prev_reg <= sda_s;
      wr_en_reg    <= 1'b0;
      // Post-write increment lands the cycle after the strobe so wr_addr
      // carries the pre-increment pointer.
      if (wr_en_reg) ptr_reg <= ptr_reg + PTR_ONE;

      if (start_det) begin
        state_reg   <= ST_ADDR;
        bit_cnt_reg <= 4'd0;
        sda_oe_reg  <= 1'b0;
        busy_reg    <= 1'b0;
      end else if (stop_det) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else begin
        unique case (state_reg)
          ST_IDLE, ST_WAIT: ;
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise && !byte_done) begin
              shift_reg   <= {shift_reg[6:0], sda_s};
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall && byte_done) begin
              bit_cnt_reg <= 4'd0;
              if (state_reg == ST_ADDR) begin
                if (shift_reg[7:1] == ADDR) begin
                  sda_oe_reg <= 1'b1;
                  busy_reg   <= 1'b1;
                  rw_reg     <= shift_reg[0];
                  state_reg  <= ST_ADDR_ACK;
                end else begin
                  sda_oe_reg <= 1'b0;
                  state_reg  <= ST_WAIT;
                end
              end else if (state_reg == ST_PTR) begin
                ptr_reg    <= shift_reg[AW-1:0];
                sda_oe_reg <= 1'b1;
                state_reg  <= ST_PTR_ACK;
              end else begin
                wr_en_reg   <= 1'b1;
                wr_addr_reg <= ptr_reg;
                wr_data_reg <= shift_reg;
                sda_oe_reg  <= 1'b1;
                state_reg   <= ST_WDATA_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall) begin
              if (!rw_reg) begin
                sda_oe_reg <= 1'b0;
                state_reg  <= ST_PTR;
              end else begin
                shift_reg  <= bus.rd_data;
                sda_oe_reg <= ~bus.rd_data[7];
                state_reg  <= ST_RDATA;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall) begin
              sda_oe_reg <= 1'b0;
              state_reg  <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise && !byte_done) begin
              bit_cnt_reg <= bit_cnt_reg + 4'd1;
            end else if (scl_fall) begin
              if (byte_done) begin
                bit_cnt_reg <= 4'd0;
                sda_oe_reg  <= 1'b0;
                state_reg   <= ST_RDATA_ACK;
              end else begin
                shift_reg  <= {shift_reg[6:0], 1'b0};
                sda_oe_reg <= ~shift_reg[6];
              end
            end
          end
          ST_RDATA_ACK: begin
            // Pointer advances on the ACK clock's rise so rd_data has settled
            // long before the next byte is loaded on the following fall.
            if (scl_rise) begin
              ptr_reg <= ptr_reg + PTR_ONE;
              if (sda_s) begin
                state_reg <= ST_WAIT;
                busy_reg  <= 1'b0;
              end
            end else if (scl_fall) begin
              shift_reg  <= bus.rd_data;
              sda_oe_reg <= ~bus.rd_data[7];
              state_reg  <= ST_RDATA;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.sda_oe  = sda_oe_reg;
  assign bus.wr_en   = wr_en_reg;
  assign bus.wr_addr = wr_addr_reg;
  assign bus.wr_data = wr_data_reg;
  assign bus.rd_addr = ptr_reg;
  assign bus.busy    = busy_reg;
endmodule

// File: tb/tb_pmod_i2c_target.sv
// tb_pmod_i2c_target -- bit-banged I2C master driving pmod_i2c_target, a small
// register file on its read/write port, and a transaction-level model that
// predicts every register write, every returned read byte and the pointer.
module tb_pmod_i2c_target;
  localparam int Q = 5;  // clk cycles per quarter SCL period

  logic clk = 1'b0;
  logic rst;
  logic scl_m, sda_m;
  always #5 clk = ~clk;

  pmod_i2c_target_if #(.AW(4)) bus ();
  assign bus.scl_i = scl_m;
  assign bus.sda_i = sda_m & ~bus.sda_oe;  // open-drain wired-AND

  // Register file seen by the DUT
  logic [7:0] env_mem [16];
  logic       poke_en;
  logic [3:0] poke_addr;
  logic [7:0] poke_data;
  assign bus.rd_data = env_mem[bus.rd_addr];
  always @(posedge clk) begin
    if (bus.wr_en) env_mem[bus.wr_addr] <= bus.wr_data;
    if (poke_en) env_mem[poke_addr] <= poke_data;
  end

  pmod_i2c_target #(.ADDR(7'h20), .AW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Model state
  int         n_pass = 0;
  int         n_total = 0;
  int         model_ptr;
  logic [7:0] model_mem [16];
  logic [3:0] exp_wr_addr [$];
  logic [7:0] exp_wr_data [$];
  logic [3:0] obs_addr [$];
  logic [7:0] obs_data [$];
  logic [7:0] rlog [$];
  logic [7:0] wq [$];
  bit         quiet;
  logic [3:0] pop_a;
  logic [7:0] pop_d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_total++;
    if (act === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
  endtask

  // Per-cycle compare against the predicted write stream
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.wr_en) begin
        obs_addr.push_back(bus.wr_addr);
        obs_data.push_back(bus.wr_data);
        if (exp_wr_addr.size() == 0) begin
          check("unexpected_wr_en", 1, 0);
        end else begin
          pop_a = exp_wr_addr.pop_front();
          pop_d = exp_wr_data.pop_front();
          check("wr_addr", bus.wr_addr, pop_a);
          check("wr_data", bus.wr_data, pop_d);
        end
      end
      if (quiet) check("sda_quiet", bus.sda_oe, 0);
    end
  end

  task automatic poke(input logic [3:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    model_mem[a] = d;
    @(posedge clk);
    #1 poke_en = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic bus_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    sda_m = 1'b1; wait_clk(Q);
  endtask

  task automatic write_bit(input bit b);
    sda_m = b;    wait_clk(Q);
    scl_m = 1'b1; wait_clk(2 * Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic read_bit(output bit b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    #1 b = bus.sda_i;
    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic write_byte(input logic [7:0] v, output bit ack);
    bit nb;
    for (int i = 7; i >= 0; i--) write_bit(v[i]);
    read_bit(nb);
    ack = ~nb;
  endtask

  task automatic read_byte(output logic [7:0] v, input bit master_ack);
    bit b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      v[i] = b;
    end
    write_bit(~master_ack);
  endtask

  // abort_where: 0 none, 1 STOP inside the byte after n data bytes, 2 STOP inside the pointer byte
  task automatic txn_write(input logic [7:0] abyte, input logic [7:0] pbyte, input int n,
                           input int abort_where, input int abort_bits);
    bit ack, match;
    logic [7:0] d;
    match = (abyte[7:1] == 7'h20) && (abyte[0] == 1'b0);
    if (!match) quiet = 1'b1;
    bus_start();
    write_byte(abyte, ack);
    check("addr_ack", ack, match);
    check("busy_after_addr", bus.busy, match);
    if (match && abort_where == 2) begin
      for (int i = 0; i < abort_bits; i++) write_bit(1'($urandom_range(0, 1)));
    end else begin
      write_byte(pbyte, ack);
      check("ptr_ack", ack, match);
      if (match) model_ptr = int'(pbyte[3:0]);
      for (int i = 0; i < n; i++) begin
        d = wq.pop_front();
        if (match) begin
          exp_wr_addr.push_back(model_ptr[3:0]);
          exp_wr_data.push_back(d);
          model_mem[model_ptr] = d;
          model_ptr = (model_ptr + 1) % 16;
        end
        write_byte(d, ack);
        check("data_ack", ack, match);
      end
      if (abort_where == 1)
        for (int i = 0; i < abort_bits; i++) write_bit(1'($urandom_range(0, 1)));
    end
    bus_stop();
    wait_clk(2);
    #1;
    check("busy_after_stop", bus.busy, 0);
    check("sda_oe_after_stop", bus.sda_oe, 0);
    check("rd_addr_after_write", bus.rd_addr, model_ptr);
    quiet = 1'b0;
  endtask

  task automatic txn_read(input bit set_ptr, input logic [7:0] pbyte, input int n);
    bit ack;
    logic [7:0] v, want;
    if (set_ptr) begin
      bus_start();
      write_byte(8'h40, ack);
      check("rd_waddr_ack", ack, 1);
      write_byte(pbyte, ack);
      check("rd_ptr_ack", ack, 1);
      model_ptr = int'(pbyte[3:0]);
    end
    bus_start();
    write_byte(8'h41, ack);
    check("raddr_ack", ack, 1);
    check("busy_in_read", bus.busy, 1);
    for (int i = 0; i < n; i++) begin
      want = model_mem[model_ptr];
      read_byte(v, i < n - 1);
      model_ptr = (model_ptr + 1) % 16;
      rlog.push_back(v);
      check("rd_byte", v, want);
    end
    #1;
    check("sda_oe_after_nack", bus.sda_oe, 0);
    check("busy_after_nack", bus.busy, 0);
    bus_stop();
    wait_clk(2);
    #1 check("rd_addr_after_read", bus.rd_addr, model_ptr);
  endtask

  initial begin
    bit ack;
    int kind, n;
    logic [7:0] abyte;
    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; quiet = 1'b0; poke_en = 1'b0; model_ptr = 0;
    wait_clk(3);
    for (int i = 0; i < 16; i++) poke(i[3:0], 8'($urandom));
    @(negedge clk) rst = 1'b0;
    wait_clk(2);
    #1;
    check("reset_sda_oe", bus.sda_oe, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_wr_en", bus.wr_en, 0);
    check("reset_rd_addr", bus.rd_addr, 0);

    // Write burst: pointer 2, data A5 5A
    obs_addr.delete(); obs_data.delete();
    wq = '{8'hA5, 8'h5A};
    txn_write(8'h40, 8'h02, 2, 0, 0);
    check("burst_wr_count", obs_addr.size(), 2);
    check("burst_addr0", obs_addr[0], 4'd2);
    check("burst_data0", obs_data[0], 8'hA5);
    check("burst_addr1", obs_addr[1], 4'd3);
    check("burst_data1", obs_data[1], 8'h5A);

    // Read with repeated START
    poke(4'd2, 8'h3C);
    poke(4'd3, 8'hC3);
    obs_addr.delete(); obs_data.delete(); rlog.delete();
    txn_read(1'b1, 8'h02, 2);
    check("read_byte0_lit", rlog[0], 8'h3C);
    check("read_byte1_lit", rlog[1], 8'hC3);
    check("read_rd_addr_lit", bus.rd_addr, 4'd4);
    check("read_no_wr", obs_addr.size(), 0);

    // Address mismatch
    wq = '{8'h99};
    txn_write(8'h42, 8'h05, 1, 0, 0);
    check("mismatch_no_wr", obs_addr.size(), 0);

    // Pointer wrap
    obs_addr.delete(); obs_data.delete();
    wq = '{8'h11, 8'h22};
    txn_write(8'h40, 8'hFF, 2, 0, 0);
    check("wrap_addr0", obs_addr[0], 4'd15);
    check("wrap_addr1", obs_addr[1], 4'd0);

    // STOP after 5 bits of a data byte
    obs_addr.delete(); obs_data.delete();
    txn_write(8'h40, 8'h07, 0, 1, 5);
    check("abort_no_wr", obs_addr.size(), 0);
    check("abort_ptr_lit", bus.rd_addr, 4'd7);

    // Reset while the DUT drives a 0 read bit
    poke(4'd5, 8'h00);
    bus_start();
    write_byte(8'h40, ack); check("rst_waddr_ack", ack, 1);
    write_byte(8'h05, ack); check("rst_ptr_ack", ack, 1);
    bus_start();
    write_byte(8'h41, ack); check("rst_raddr_ack", ack, 1);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    #1;
    check("drive_before_rst", bus.sda_oe, 1);
    check("busy_before_rst", bus.busy, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_read_sda_oe", bus.sda_oe, 0);
    check("rst_mid_read_busy", bus.busy, 0);
    check("rst_mid_read_rd_addr", bus.rd_addr, 0);
    rst = 1'b0;
    model_ptr = 0;
    wait_clk(4 * Q);

    // Randomized traffic
    for (int t = 0; t < 20; t++) begin
      kind = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      case (kind)
        0: begin
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          txn_write(8'h40, 8'($urandom), n, 0, 0);
        end
        1: txn_read(1'($urandom_range(0, 1)), 8'($urandom), n);
        2: begin
          abyte = 8'($urandom);
          if (abyte[7:1] == 7'h20) abyte[7] = ~abyte[7];
          wq.push_back(8'($urandom));
          txn_write(abyte, 8'($urandom), 1, 0, 0);
        end
        3: begin
          n = $urandom_range(0, 2);
          for (int i = 0; i < n; i++) wq.push_back(8'($urandom));
          txn_write(8'h40, 8'($urandom), n, 1, $urandom_range(1, 7));
        end
        default: txn_write(8'h40, 8'($urandom), 0, 2, $urandom_range(1, 7));
      endcase
    end

    wait_clk(4);
    check("pending_writes", exp_wr_addr.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
